// File: rtl/mul_wb_buffer.sv
// Writeback buffer behind the iterative 32x32 multiplier.
// The multiplier cannot stall, so every product is queued here. The selected
// 32-bit word is tagged with the issuer's destination and offered to the
// register-file writeback port. iss_allow gates new issues so the queue
// always has room for each result that is in flight.
module mul_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_fire,
  input  logic [TAG_W-1:0]         iss_tag,
  input  logic                     iss_hi,
  output logic                     iss_allow,
  input  logic                     mul_valid,
  input  logic [63:0]              mul_result,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [31:0]              wb_data,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);

  // Pending request: tag and word select of the single multiply in flight.
  logic [TAG_W-1:0] pend_tag_reg;
  logic             pend_hi_reg;
  logic             inflight_reg;
  logic             inflight_next;

  // Result queue storage and pointers; storage is not reset.
  logic [31:0]      data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             err_reg, err_next;

  logic             push_req;
  logic             full;
  logic             push;
  logic             pop;
  logic [31:0]      push_data;
  logic [CW:0]      occupancy;

  // Credit and handshake terms are derived from registered state only, so a
  // pop can raise iss_allow no earlier than the following cycle.
  always_comb begin
    full      = (count_reg == FULL_COUNT);
    push_req  = mul_valid && inflight_reg;
    push      = push_req && !full;
    pop       = wb_valid && wb_ready;
    push_data = pend_hi_reg ? mul_result[63:32] : mul_result[31:0];
    occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    iss_allow = (occupancy < CREDIT_LIMIT);
    wb_valid  = (count_reg != '0);
    wb_data   = data_mem[rd_ptr_reg];
    wb_tag    = tag_mem[rd_ptr_reg];
    wb_count  = count_reg;
    err       = err_reg;
  end

  // Next-state for pointers, occupancy, in-flight flag and the sticky error.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    inflight_next = inflight_reg;
    err_next      = err_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
    // A new issue wins over a completing one: the slot is refilled at once.
    if (iss_fire) begin
      inflight_next = 1'b1;
    end else if (mul_valid) begin
      inflight_next = 1'b0;
    end
    if ((push_req && full) ||
        (mul_valid && !inflight_reg) ||
        (iss_fire && inflight_reg && !mul_valid) ||
        (iss_fire && !iss_allow)) begin
      err_next = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_next;
    end
  end

  // Pending register loads on issue; a same-cycle push has already used the
  // old contents because the queue write reads them in this same edge.
  always_ff @(posedge clk) begin
    if (iss_fire) begin
      pend_tag_reg <= iss_tag;
      pend_hi_reg  <= iss_hi;
    end
  end

  // Queue write at the tail; data is never cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr_reg] <= push_data;
      tag_mem[wr_ptr_reg]  <= pend_tag_reg;
    end
  end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed bench for mul_wb_buffer with a queue-based reference model and a
// per-cycle compare process, plus literal checks that pin the model.
module tb_mul_wb_buffer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              iss_fire;
  logic [TAG_W-1:0]  iss_tag;
  logic              iss_hi;
  logic              iss_allow;
  logic              mul_valid;
  logic [63:0]       mul_result;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic [$clog2(DEPTH):0] wb_count;
  logic              err;

  mul_wb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .iss_fire   (iss_fire),
    .iss_tag    (iss_tag),
    .iss_hi     (iss_hi),
    .iss_allow  (iss_allow),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_tag     (wb_tag),
    .wb_count   (wb_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of {tag, word} plus the pending request.
  logic [TAG_W+31:0] m_q[$];
  logic [TAG_W-1:0]  m_tag;
  logic              m_hi;
  bit                m_inflight;
  bit                m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge of the behavioural rules to the model.
  task automatic model_update();
    int sz;
    bit allow;
    bit push;
    logic [TAG_W+31:0] ent;
    sz    = m_q.size();
    allow = (sz + int'(m_inflight)) < DEPTH;
    push  = mul_valid && m_inflight;
    if (reset) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_err      = 1'b0;
      return;
    end
    if (mul_valid && !m_inflight) m_err = 1'b1;
    if (iss_fire && m_inflight && !mul_valid) m_err = 1'b1;
    if (iss_fire && !allow) m_err = 1'b1;
    ent = {m_tag, (m_hi ? mul_result[63:32] : mul_result[31:0])};
    if (sz != 0 && wb_ready) void'(m_q.pop_front());
    if (push) begin
      if (sz == DEPTH) m_err = 1'b1;
      else m_q.push_back(ent);
    end
    if (iss_fire) begin
      m_tag = iss_tag;
      m_hi  = iss_hi;
      m_inflight = 1'b1;
    end else if (mul_valid) begin
      m_inflight = 1'b0;
    end
  endtask

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_valid", 64'(wb_valid), 64'(m_q.size() != 0));
      chk("wb_count", 64'(wb_count), 64'(m_q.size()));
      chk("iss_allow", 64'(iss_allow), 64'((m_q.size() + int'(m_inflight)) < DEPTH));
      chk("err", 64'(err), 64'(m_err));
      if (m_q.size() != 0) begin
        chk("wb_data", 64'(wb_data), 64'(m_q[0][31:0]));
        chk("wb_tag", 64'(wb_tag), 64'(m_q[0][TAG_W+31:32]));
      end
      $display("cyc t=%0t valid=%0b tag=%0d data=%h count=%0d allow=%0b err=%0b",
               $time, wb_valid, wb_tag, wb_data, wb_count, iss_allow, err);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic issue(input logic [TAG_W-1:0] t, input logic h);
    iss_fire = 1'b1; iss_tag = t; iss_hi = h;
    tick();
    iss_fire = 1'b0;
  endtask

  task automatic complete(input logic [63:0] r);
    mul_valid = 1'b1; mul_result = r;
    tick();
    mul_valid = 1'b0;
  endtask

  function automatic logic [63:0] mk(input logic [TAG_W-1:0] t);
    return {8'hC0, 19'd0, t, 8'h5A, 19'd0, t};
  endfunction

  initial begin
    reset = 1'b1; iss_fire = 1'b0; iss_tag = '0; iss_hi = 1'b0;
    mul_valid = 1'b0; mul_result = '0; wb_ready = 1'b0;
    m_tag = '0; m_hi = 1'b0; m_inflight = 1'b0; m_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", 64'(wb_valid), 64'd0);
    chk("reset_count", 64'(wb_count), 64'd0);
    chk("reset_allow", 64'(iss_allow), 64'd1);
    chk("reset_err", 64'(err), 64'd0);

    // 1: low word, six cycles of multiply latency
    issue(5'd3, 1'b0);
    repeat (5) tick();
    chk("t1_latency", 64'(wb_valid), 64'd0);
    complete(64'h0000_0002_FFFF_FFFE);
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_data", 64'(wb_data), 64'hFFFF_FFFE);
    chk("t1_tag", 64'(wb_tag), 64'd3);
    tick();
    chk("t1_hold", 64'(wb_data), 64'hFFFF_FFFE);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // 2: high word
    issue(5'd3, 1'b1);
    repeat (5) tick();
    complete(64'h0000_0002_FFFF_FFFE);
    chk("t2_data", 64'(wb_data), 64'h0000_0002);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // 3: fill to DEPTH with the consumer stalled, then drain in order
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 1'(i % 2));
      complete(mk(5'(i)));
    end
    chk("t3_count", 64'(wb_count), 64'd4);
    chk("t3_allow_full", 64'(iss_allow), 64'd0);
    wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_tag", 64'(wb_tag), 64'(i));
      tick();
      if (i == 1) chk("t3_allow", 64'(iss_allow), 64'd1);
    end
    wb_ready = 1'b0;

    // 4: back-to-back issue with same-cycle completion, then push+pop at 3
    iss_fire = 1'b1; iss_tag = 5'd5; iss_hi = 1'b0; tick();
    mul_valid = 1'b1; mul_result = mk(5'd5); iss_tag = 5'd6; iss_hi = 1'b1; tick();
    mul_result = mk(5'd6); iss_tag = 5'd7; iss_hi = 1'b0; tick();
    iss_fire = 1'b0; mul_result = mk(5'd7); tick();
    mul_valid = 1'b0;
    chk("t4_head6", 64'({wb_tag, wb_data}), 64'({5'd5, 32'h5A00_0005}));
    chk("t4_fill", 64'(wb_count), 64'd3);
    issue(5'd8, 1'b1);
    wb_ready = 1'b1;
    complete(mk(5'd8));
    chk("t4_count", 64'(wb_count), 64'd3);
    for (int i = 6; i <= 8; i++) begin
      chk("t4_tag", 64'(wb_tag), 64'(i));
      tick();
    end
    wb_ready = 1'b0;
    chk("t4_empty", 64'(wb_count), 64'd0);

    // 5: completion with nothing in flight is an error; err is sticky
    complete(mk(5'd9));
    chk("t5_count", 64'(wb_count), 64'd0);
    chk("t5_err", 64'(err), 64'd1);
    repeat (3) tick();
    chk("t5_sticky", 64'(err), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_clear", 64'(err), 64'd0);

    // Overwrite of a pending request is an error
    issue(5'd9, 1'b0);
    issue(5'd10, 1'b1);
    chk("ovw_err", 64'(err), 64'd1);
    complete(mk(5'd10));
    reset = 1'b1; tick(); reset = 1'b0;

    // Issue without credit, then push while full
    for (int i = 11; i <= 14; i++) begin
      issue(5'(i), 1'b0);
      complete(mk(5'(i)));
    end
    issue(5'd15, 1'b0);
    chk("nocredit_err", 64'(err), 64'd1);
    complete(mk(5'd15));
    chk("full_count", 64'(wb_count), 64'd4);
    chk("full_head", 64'(wb_tag), 64'd11);
    reset = 1'b1; tick(); reset = 1'b0;

    // 6: reset mid-operation
    issue(5'd20, 1'b0); complete(mk(5'd20));
    issue(5'd21, 1'b1); complete(mk(5'd21));
    issue(5'd22, 1'b0);
    chk("t6_pre", 64'(wb_count), 64'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_valid", 64'(wb_valid), 64'd0);
    chk("t6_count", 64'(wb_count), 64'd0);
    chk("t6_allow", 64'(iss_allow), 64'd1);
    chk("t6_err", 64'(err), 64'd0);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
